// File: rtl/dram_sched.sv
// Purpose : DRAM sequencer behind the FSB; arbitrates CPU RAM cycles against CBR refresh and drives nRAS/nCAS/WE/OE/RASEL.
// Latency : RAMReady asserts 2 FCLK edges after the edge where a CPU request is first seen in IDLE (1 edge ROW, then COL).
// Backpress: a CPU request seen while busy simply waits (BACT held); refresh ticks queue in a 2-bit pending counter that saturates at REF_MAX.
//
// Ports:
//   FCLK, RES                      clock (rising edge), asynchronous active-high reset
//   BACT, RAMCS, nWE_FSB           FSB cycle qualifier, DRAM chip-select, write (low)
//   nLDS_FSB, nUDS_FSB             byte strobes, passed to nRAMLWE/nRAMUWE while in COL on writes
//   RefClk                         FCLK-synchronous refresh level; each rising edge is one request
//   RASEL, nRAS, nCAS, nOE         address mux select and DRAM strobes (registered)
//   nRAMLWE, nRAMUWE               byte write enables (registered write flag gated by live byte strobes)
//   RAMReady                       data valid / write done for the current FSB cycle
//   RefOvf                         sticky: a tick was dropped because the pending counter was full
//
// Build option: define DRAM_SCHED_REFDEFER_EN to let CPU requests win over refresh in IDLE
// unless the pending counter is saturated.
module dram_sched #(
    parameter int TRP     = 2,
    parameter int TRAS    = 3,
    parameter int REF_MAX = 3
) (
    input  logic FCLK,
    input  logic RES,
    input  logic BACT,
    input  logic RAMCS,
    input  logic nWE_FSB,
    input  logic nLDS_FSB,
    input  logic nUDS_FSB,
    input  logic RefClk,
    output logic RASEL,
    output logic nRAS,
    output logic nCAS,
    output logic nRAMLWE,
    output logic nRAMUWE,
    output logic nOE,
    output logic RAMReady,
    output logic RefOvf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW,
        S_COL,
        S_REF_CAS,
        S_REF_RAS,
        S_PRE
    } state_t;

    localparam logic [1:0] REF_SAT  = 2'(REF_MAX);
    localparam logic [3:0] TRP_LAST  = 4'(TRP - 1);
    localparam logic [3:0] TRAS_LAST = 4'(TRAS - 1);

    state_t     r_state;
    logic [1:0] r_pending;
    logic [3:0] r_cnt;
    logic       r_refclk_q;
    logic       r_ovf;
    logic       r_rasel;
    logic       r_ras_n;
    logic       r_cas_n;
    logic       r_oe_n;
    logic       r_ready;
    logic       r_wr;

    logic w_tick;
    logic w_cpu_req;
    logic w_ref_go;
    logic w_cpu_go;

    assign w_tick    = RefClk & ~r_refclk_q;
    assign w_cpu_req = BACT & RAMCS;

`ifdef DRAM_SCHED_REFDEFER_EN
    // Refresh yields to the CPU until the backlog is full.
    assign w_ref_go = (r_state == S_IDLE) && (r_pending != 2'd0) &&
                      (!w_cpu_req || (r_pending == REF_SAT));
`else
    assign w_ref_go = (r_state == S_IDLE) && (r_pending != 2'd0);
`endif
    assign w_cpu_go = (r_state == S_IDLE) && w_cpu_req && !w_ref_go;

    // Strobe registers are loaded from the state being left, so each state's
    // pins appear for exactly its own duration one edge later; the COL exit is
    // the exception and releases all strobes on the edge BACT is seen low.
    always_ff @(posedge FCLK or posedge RES) begin
        if (RES) begin
            r_state    <= S_IDLE;
            r_pending  <= 2'd0;
            r_cnt      <= 4'd0;
            r_refclk_q <= 1'b0;
            r_ovf      <= 1'b0;
            r_rasel    <= 1'b1;
            r_ras_n    <= 1'b1;
            r_cas_n    <= 1'b1;
            r_oe_n     <= 1'b1;
            r_ready    <= 1'b0;
            r_wr       <= 1'b0;
        end else begin
            r_refclk_q <= RefClk;

            // A tick coinciding with REF_CAS entry cancels out, even when saturated.
            if (w_tick && !w_ref_go) begin
                if (r_pending == REF_SAT) r_ovf <= 1'b1;
                else                      r_pending <= r_pending + 2'd1;
            end else if (!w_tick && w_ref_go) begin
                r_pending <= r_pending - 2'd1;
            end

            r_rasel <= 1'b1;
            r_ras_n <= 1'b1;
            r_cas_n <= 1'b1;
            r_oe_n  <= 1'b1;
            r_ready <= 1'b0;
            r_wr    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_ref_go)      r_state <= S_REF_CAS;
                    else if (w_cpu_go) r_state <= S_ROW;
                end
                S_ROW: begin
                    r_ras_n <= 1'b0;
                    r_state <= S_COL;
                end
                S_COL: begin
                    if (BACT) begin
                        r_ras_n <= 1'b0;
                        r_cas_n <= 1'b0;
                        r_rasel <= 1'b0;
                        r_ready <= 1'b1;
                        r_oe_n  <= ~nWE_FSB;
                        r_wr    <= ~nWE_FSB;
                    end else begin
                        r_cnt   <= 4'd0;
                        r_state <= S_PRE;
                    end
                end
                S_REF_CAS: begin
                    r_cas_n <= 1'b0;
                    r_cnt   <= 4'd0;
                    r_state <= S_REF_RAS;
                end
                S_REF_RAS: begin
                    r_cas_n <= 1'b0;
                    r_ras_n <= 1'b0;
                    if (r_cnt == TRAS_LAST) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_PRE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_PRE: begin
                    if (r_cnt == TRP_LAST) r_state <= S_IDLE;
                    else                   r_cnt   <= r_cnt + 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RASEL    = r_rasel;
    assign nRAS     = r_ras_n;
    assign nCAS     = r_cas_n;
    assign nOE      = r_oe_n;
    assign RAMReady = r_ready;
    assign RefOvf   = r_ovf;
    // Byte enables track the live FSB strobes while a write is in COL.
    assign nRAMLWE  = ~r_wr | nLDS_FSB;
    assign nRAMUWE  = ~r_wr | nUDS_FSB;

endmodule

// File: doc/dram_sched.md
Name: dram_sched

Overview:
- Sequences the 30-pin DRAM array behind the FSB.
- Arbitrates between CPU RAM cycles (RAMCS during BACT) and CAS-before-RAS refresh requests from the RefClk tick.
- Drives the nRAS/nCAS/write strobes and the row/column address mux select.
- Returns RAMReady to the FSB termination logic; sits between the chip-select decode and the RA/nRAS/nCAS pins.

Parameters:
- TRP, 2: precharge cycles (nRAS high) after any RAS cycle, min 1.
- TRAS, 3: nRAS-low cycles for a refresh, min 1.
- REF_MAX, 3: saturation limit of the pending-refresh counter, 1..3.

Ports:
- FCLK  in  1  FSB clock; all state on rising edge.
- RES  in  1  asynchronous active-high reset.
- BACT  in  1  FSB bus cycle active (/AS qualified).
- RAMCS  in  1  current cycle addresses DRAM.
- nWE_FSB  in  1  CPU write when low.
- nLDS_FSB  in  1  lower data strobe.
- nUDS_FSB  in  1  upper data strobe.
- RefClk  in  1  refresh tick, FCLK-synchronous level; rising edge = one request.
- RASEL  out  1  1 = row address on RA, 0 = column.
- nRAS  out  1  DRAM row strobe.
- nCAS  out  1  DRAM column strobe.
- nRAMLWE  out  1  lower-byte write enable.
- nRAMUWE  out  1  upper-byte write enable.
- nOE  out  1  DRAM read output enable.
- RAMReady  out  1  DRAM data valid / write done for this FSB cycle.
- RefOvf  out  1  sticky: a refresh tick arrived while the counter was saturated.

Behaviour:
- Reset (async, RES=1):
  - State IDLE, pending=0, RefOvf=0, RASEL=1.
  - nRAS=nCAS=nRAMLWE=nRAMUWE=nOE=1, RAMReady=0.
  - Strobes deassert immediately, mid-cycle or not.
- Refresh edge detect: RefClk registered once; a tick is RefClk=1 while the previous sample is 0.
- Pending counter, 2 bits:
  - +1 on a tick; -1 when REF_CAS is entered; tick and entry in the same cycle leave it unchanged.
  - A tick at pending=REF_MAX is dropped and sets RefOvf.
- CPU request: BACT & RAMCS. A request asserted in a cycle where the block is busy waits; it is never lost while BACT stays high.
- Arbitration, IDLE only:
  - Refresh wins if pending>0; otherwise a CPU request starts ROW. See Optional Feature for the alternative.
- CPU access states:
  - ROW: nRAS=0, RASEL=1; 1 cycle, then COL.
  - COL: RASEL=0, nCAS=0, RAMReady=1. On reads nOE=0. On writes nRAMLWE=nLDS_FSB and nRAMUWE=nUDS_FSB (active low). Stays in COL until BACT=0.
  - BACT=0 in COL: all strobes high, RAMReady=0, go to PRE.
  - RAMReady latency: asserted 2 FCLK edges after the first edge where the request is seen in IDLE.
- Refresh states:
  - REF_CAS: nCAS=0, nRAS=1; 1 cycle.
  - REF_RAS: nCAS=0, nRAS=0 for TRAS cycles.
  - Then PRE.
  - RAMReady stays 0 throughout refresh, even with a CPU request pending.
- PRE: nRAS=nCAS=1, RASEL=1 for TRP cycles, then IDLE.
- nRAS and nCAS are never both high→low on the same edge. A CBR sequence always drops nCAS one cycle before nRAS.
- BACT dropping before COL (aborted cycle): finish ROW→COL, deassert on the next edge, then PRE. No stuck RAMReady.
- Write strobe changes (nLDS/nUDS) inside COL are followed combinationally from registered state.

Optional Feature:
- Macro: DRAM_SCHED_REFDEFER_EN.
- Defined: in IDLE a CPU request wins over refresh unless pending=REF_MAX. Refresh is deferred across bursts and runs in the first idle slot or when saturated.
- Undefined: refresh wins whenever pending>0 (behaviour above).
- Counter and RefOvf rules are identical in both builds.

Test Plan:
1. Reset mid-cycle: RES=1 while in COL → nRAS, nCAS, nOE and RAMReady go inactive without a clock edge. After release: IDLE, pending=0.
2. CPU read, no refresh pending: BACT=RAMCS=1, nWE_FSB=1 at edge 0 → nRAS=0 after edge 1; nCAS=0, nOE=0, RAMReady=1 after edge 2. BACT=0 → strobes high next edge, then 2 PRE cycles.
3. CPU write, nLDS_FSB=0, nUDS_FSB=1 → nRAMLWE=0 and nRAMUWE=1 only while in COL; nOE=1 throughout.
4. Refresh priority (macro off): pending=1 and CPU request in IDLE → nCAS=0 one cycle before nRAS=0; nRAS low 3 cycles; 2 PRE cycles. The CPU access then starts; pending=0.
5. Saturation: 4 ticks with BACT held in COL → pending=3, RefOvf=1. After release: three back-to-back refreshes, pending=0, RefOvf still 1.
6. Macro on: pending=1 plus CPU request → CPU served first. Pending=3 plus CPU request → refresh first.
